sample_dma_request_scheduler: RTL and testbench
===============================================

Name: sample_dma_request_scheduler

Overview:
Sequences sample-fetch DMA requests for up to MAX_VOICES concurrently playing voices. It holds a per-voice read pointer and a remaining-length table. Each batch, it issues one burst request per active voice, in ascending voice ID order, to the AXI read bridge. It flags the last request of the batch to the sample DMA receiver, then waits for the receiver's all_samples_received before starting the next batch.

Parameters:
MAX_VOICES, 64, number of voice slots; IDs are 6 bits, so MAX_VOICES is at most 64.
ADDR_WIDTH, 32, byte address width of sample memory.
BURST_LEN, 16, maximum 32-bit words per request (1..256).

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
stop  in  1  abort: clears all voices and returns to IDLE
voice_start  in  1  one-cycle pulse: load a voice slot
voice_start_id  in  6  slot to load
voice_start_addr  in  ADDR_WIDTH  byte start address of sample (word aligned)
voice_start_len  in  24  sample length in 32-bit words
voice_active  out  MAX_VOICES  per-slot active flags
voice_done  out  1  one-cycle pulse: voice's final request accepted
voice_done_id  out  6  ID of the finished voice
req_valid  out  1  request valid
req_ready  in  1  bridge accepts request
req_addr  out  ADDR_WIDTH  burst byte address
req_len  out  9  burst length in words (1..BURST_LEN)
req_id  out  6  voice ID; the bridge returns it on TUSER[5:0]
last_request_sent  out  1  one-cycle pulse on handshake of the batch's last request
last_request_id  out  6  ID of that request; valid while last_request_sent=1
all_samples_invalid  out  1  high when no voice is active
all_samples_received  in  1  pulse from receiver: batch fully drained

Behaviour:
- Reset values:
  - voice_active=0, all_samples_invalid=1.
  - req_valid=0, req_addr/req_len/req_id=0.
  - last_request_sent=0, last_request_id=0.
  - voice_done=0, voice_done_id=0.
  - FSM in IDLE.
- Tables: addr_tbl[MAX_VOICES][ADDR_WIDTH] and rem_tbl[MAX_VOICES][24], registered, not reset.
- all_samples_invalid = ~|voice_active, driven combinationally from the registered vector.
- voice_start:
  - Writes addr/len and sets voice_active[id] at the next edge.
  - voice_start_len=0 is ignored.
  - Restarting an already-active slot reloads it.
  - voice_start takes priority over a same-cycle handshake update of the same slot.
- Handshake: a transfer occurs when req_valid && req_ready.
  - req_* remain stable while req_valid=1 && req_ready=0.
  - req_valid deasserts only after the handshake, or on stop.
- Burst sizing: req_len = min(rem_tbl[id], BURST_LEN).
- On handshake:
  - addr_tbl += req_len*4 (modulo 2^ADDR_WIDTH).
  - rem_tbl -= req_len.
  - If rem becomes 0: clear voice_active[id] next edge and pulse voice_done with voice_done_id=id.
- FSM states:
  - IDLE: go to SEARCH with scan_ptr=0 when |voice_active && ~stop.
  - SEARCH: cur = lowest active index >= scan_ptr, found by combinational priority encoder.
    - If found: latch cur, load req_*, go to ISSUE with req_valid=1.
    - If none found: go to WAIT_BATCH if at least one request was issued this batch, else IDLE.
  - ISSUE: hold req_valid until handshake.
    - At handshake, is_last = no bit set in voice_active above cur, using the registered vector.
    - If is_last: pulse last_request_sent with last_request_id=cur, and go to WAIT_BATCH.
    - Otherwise: scan_ptr=cur+1, go to SEARCH.
  - WAIT_BATCH: on all_samples_received, go to SEARCH with scan_ptr=0, or to IDLE if no voice is active.
- Latency: voice_start at cycle T into an idle scheduler gives req_valid=1 at T+3.
- A voice started mid-batch:
  - Index above cur: it joins the current batch.
  - Started in the same cycle as the last handshake, or after it: it joins the next batch.
- stop (synchronous, any state), applied at the next edge:
  - FSM goes to IDLE, voice_active clears, req_valid drops, the batch-issued flag clears.
  - No voice_done or last_request_sent pulses are generated.
- Asynchronous reset mid-burst: all outputs return to their reset values immediately.

Test Plan:
- Reset: assert reset_n=0 mid-ISSUE -> req_valid=0, voice_active=0, all_samples_invalid=1 immediately.
- Single voice, id=3, addr=0x1000, len=40, req_ready=1, receiver pulses all_samples_received 20 cycles after each last:
  - Expect three batches: (0x1000,16), (0x1040,16), (0x1080,8).
  - last_request_sent with id=3 on each handshake.
  - voice_done(3) on the third handshake; all_samples_invalid=1 afterwards.
- Voices 2, 5 and 63, len=32 each:
  - Each batch issues IDs in order 2, 5, 63.
  - last_request_sent pulses once per batch, with id=63.
  - Exactly two batches.
- Backpressure: req_ready=0 for 10 cycles during ISSUE -> req_addr/len/id stable and req_valid held; no duplicate requests.
- Voice 10 started mid-batch after voice 5 has been issued (cur=5, voices 5 and 63 active) -> ID 10 is issued before 63 in the same batch.
- stop asserted in WAIT_BATCH and in ISSUE:
  - Next cycle: IDLE, voice_active=0, req_valid=0.
  - No last_request_sent pulse.
  - Restarting voice 1 afterwards yields a fresh request at its start_addr.

Source files
------------

// File: rtl/sample_dma_request_scheduler_if.sv
// sample_dma_request_scheduler_if: burst request channel from the scheduler to the AXI read bridge
interface sample_dma_request_scheduler_if #(parameter int ADDR_WIDTH = 32);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [8:0]            req_len;
  logic [5:0]            req_id;
  modport master (output req_valid, req_addr, req_len, req_id, input req_ready);
  modport slave (input req_valid, req_addr, req_len, req_id, output req_ready);
endinterface

// File: rtl/sample_dma_request_scheduler.sv
// sample_dma_request_scheduler: issues one burst per active voice per batch in ascending ID order
module sample_dma_request_scheduler #(
  parameter int MAX_VOICES = 64,
  parameter int ADDR_WIDTH = 32,
  parameter int BURST_LEN  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  stop,
  input  logic                  voice_start,
  input  logic [5:0]            voice_start_id,
  input  logic [ADDR_WIDTH-1:0] voice_start_addr,
  input  logic [23:0]           voice_start_len,
  output logic [MAX_VOICES-1:0] voice_active,
  output logic                  voice_done,
  output logic [5:0]            voice_done_id,
  sample_dma_request_scheduler_if.master req,
  output logic                  last_request_sent,
  output logic [5:0]            last_request_id,
  output logic                  all_samples_invalid,
  input  logic                  all_samples_received
);
  typedef enum logic [1:0] {IDLE, SEARCH, ISSUE, WAIT_BATCH} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] addr_tbl [MAX_VOICES];
  logic [23:0] rem_tbl [MAX_VOICES];
  logic [6:0] scan_ptr;
  logic [5:0] cur, idx;
  logic [8:0] burst;
  logic found, is_last, issued, hs, start_ok, reload, done_now;
  assign all_samples_invalid = ~|voice_active;
  assign start_ok = voice_start && voice_start_len != 24'd0;
  assign hs = state == ISSUE && req.req_valid && req.req_ready;
  // a restart of the slot being issued wins over the handshake bookkeeping
  assign reload = start_ok && voice_start_id == cur;
  assign done_now = hs && !reload && rem_tbl[cur] == 24'(req.req_len);
  assign burst = rem_tbl[idx] > 24'(BURST_LEN) ? 9'(BURST_LEN) : rem_tbl[idx][8:0];
  always_comb begin
    found = 1'b0;
    idx = '0;
    is_last = 1'b1;
    for (int i = MAX_VOICES - 1; i >= 0; i--) begin
      if (voice_active[i] && 7'(i) >= scan_ptr) begin
        found = 1'b1;
        idx = 6'(i);
      end
      if (voice_active[i] && 7'(i) > {1'b0, cur}) is_last = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (hs && !reload) begin
      addr_tbl[cur] <= addr_tbl[cur] + ADDR_WIDTH'({req.req_len, 2'b00});
      rem_tbl[cur] <= rem_tbl[cur] - 24'(req.req_len);
    end
    if (start_ok) begin
      addr_tbl[voice_start_id] <= voice_start_addr;
      rem_tbl[voice_start_id] <= voice_start_len;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      voice_active <= '0;
      req.req_valid <= 1'b0;
      req.req_addr <= '0;
      req.req_len <= '0;
      req.req_id <= '0;
      last_request_sent <= 1'b0;
      last_request_id <= '0;
      voice_done <= 1'b0;
      voice_done_id <= '0;
      scan_ptr <= '0;
      cur <= '0;
      issued <= 1'b0;
    end else begin
      last_request_sent <= 1'b0;
      voice_done <= 1'b0;
      if (stop) begin
        state <= IDLE;
        voice_active <= '0;
        req.req_valid <= 1'b0;
        issued <= 1'b0;
      end else begin
        if (done_now) begin
          voice_active[cur] <= 1'b0;
          voice_done <= 1'b1;
          voice_done_id <= cur;
        end
        if (start_ok) voice_active[voice_start_id] <= 1'b1;
        case (state)
          IDLE: if (|voice_active) begin
            state <= SEARCH;
            scan_ptr <= '0;
            issued <= 1'b0;
          end
          SEARCH: if (found) begin
            cur <= idx;
            req.req_addr <= addr_tbl[idx];
            req.req_len <= burst;
            req.req_id <= idx;
            req.req_valid <= 1'b1;
            issued <= 1'b1;
            state <= ISSUE;
          end else state <= issued ? WAIT_BATCH : IDLE;
          ISSUE: if (hs) begin
            req.req_valid <= 1'b0;
            if (is_last) begin
              last_request_sent <= 1'b1;
              last_request_id <= cur;
              state <= WAIT_BATCH;
            end else begin
              scan_ptr <= {1'b0, cur} + 7'd1;
              state <= SEARCH;
            end
          end
          default: if (all_samples_received) begin
            state <= |voice_active ? SEARCH : IDLE;
            scan_ptr <= '0;
            issued <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sample_dma_request_scheduler.sv
// tb_sample_dma_request_scheduler: directed checks of batch ordering, backpressure, stop and reset
module tb_sample_dma_request_scheduler;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic stop = 1'b0;
  logic voice_start = 1'b0;
  logic [5:0] voice_start_id = '0;
  logic [31:0] voice_start_addr = '0;
  logic [23:0] voice_start_len = '0;
  logic [63:0] voice_active;
  logic voice_done;
  logic [5:0] voice_done_id;
  logic last_request_sent;
  logic [5:0] last_request_id;
  logic all_samples_invalid;
  logic all_samples_received = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [5:0] q_id[$], ex_id[$], q_last[$], ex_last[$], q_done[$], ex_done[$];
  logic [31:0] q_addr[$], ex_addr[$];
  logic [8:0] q_len[$], ex_len[$];
  sample_dma_request_scheduler_if #(.ADDR_WIDTH(32)) bus ();
  sample_dma_request_scheduler dut (
    .clk(clk), .reset_n(reset_n), .stop(stop), .voice_start(voice_start),
    .voice_start_id(voice_start_id), .voice_start_addr(voice_start_addr),
    .voice_start_len(voice_start_len), .voice_active(voice_active),
    .voice_done(voice_done), .voice_done_id(voice_done_id), .req(bus.master),
    .last_request_sent(last_request_sent), .last_request_id(last_request_id),
    .all_samples_invalid(all_samples_invalid), .all_samples_received(all_samples_received)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    if (bus.req_valid && bus.req_ready) begin
      q_id.push_back(bus.req_id);
      q_addr.push_back(bus.req_addr);
      q_len.push_back(bus.req_len);
    end
    @(posedge clk);
    #1;
    if (last_request_sent) q_last.push_back(last_request_id);
    if (voice_done) q_done.push_back(voice_done_id);
  endtask
  task automatic start(input logic [5:0] id, input logic [31:0] addr, input logic [23:0] len);
    voice_start = 1'b1;
    voice_start_id = id;
    voice_start_addr = addr;
    voice_start_len = len;
    cyc();
    voice_start = 1'b0;
  endtask
  task automatic exp_req(input logic [5:0] id, input logic [31:0] addr, input logic [8:0] len);
    ex_id.push_back(id);
    ex_addr.push_back(addr);
    ex_len.push_back(len);
  endtask
  // receiver model: pulse all_samples_received about 20 cycles after each last request
  task automatic run(input int n);
    int cd = -1;
    for (int c = 0; c < n; c++) begin
      all_samples_received = 1'b0;
      if (cd == 0) begin
        all_samples_received = 1'b1;
        cd = -1;
      end
      cyc();
      if (last_request_sent) cd = 20;
      else if (cd > 0) cd--;
    end
    all_samples_received = 1'b0;
  endtask
  task automatic wait_valid(input string tag);
    int n = 0;
    while (!bus.req_valid && n < 10) begin
      cyc();
      n++;
    end
    chk({tag, "_req_valid_timeout"}, bus.req_valid, 1);
  endtask
  task automatic check_all(input string tag);
    chk({tag, "_nreq"}, q_id.size(), ex_id.size());
    for (int i = 0; i < ex_id.size() && i < q_id.size(); i++) begin
      chk($sformatf("%s_id%0d", tag, i), q_id[i], ex_id[i]);
      chk($sformatf("%s_addr%0d", tag, i), q_addr[i], ex_addr[i]);
      chk($sformatf("%s_len%0d", tag, i), q_len[i], ex_len[i]);
    end
    chk({tag, "_nlast"}, q_last.size(), ex_last.size());
    for (int i = 0; i < ex_last.size() && i < q_last.size(); i++)
      chk($sformatf("%s_last%0d", tag, i), q_last[i], ex_last[i]);
    chk({tag, "_ndone"}, q_done.size(), ex_done.size());
    for (int i = 0; i < ex_done.size() && i < q_done.size(); i++)
      chk($sformatf("%s_done%0d", tag, i), q_done[i], ex_done[i]);
    q_id.delete(); q_addr.delete(); q_len.delete(); q_last.delete(); q_done.delete();
    ex_id.delete(); ex_addr.delete(); ex_len.delete(); ex_last.delete(); ex_done.delete();
  endtask
  initial begin
    bus.req_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_active", voice_active, 0);
    chk("rst_invalid", all_samples_invalid, 1);
    chk("rst_valid", bus.req_valid, 0);
    chk("rst_addr", bus.req_addr, 0);
    chk("rst_len", bus.req_len, 0);
    chk("rst_id", bus.req_id, 0);
    chk("rst_last", last_request_sent, 0);
    chk("rst_last_id", last_request_id, 0);
    chk("rst_done", voice_done, 0);
    chk("rst_done_id", voice_done_id, 0);
    reset_n = 1'b1;
    cyc();
    // single voice, three batches, request latency
    bus.req_ready = 1'b1;
    start(6'd3, 32'h1000, 24'd40);
    chk("single_active", voice_active, 64'h8);
    chk("single_invalid", all_samples_invalid, 0);
    cyc();
    chk("lat_t2", bus.req_valid, 0);
    cyc();
    chk("lat_t3", bus.req_valid, 1);
    run(150);
    exp_req(3, 32'h1000, 16); exp_req(3, 32'h1040, 16); exp_req(3, 32'h1080, 8);
    ex_last = '{3, 3, 3};
    ex_done = '{3};
    check_all("single");
    chk("single_end_invalid", all_samples_invalid, 1);
    chk("single_end_valid", bus.req_valid, 0);
    // start-length zero is ignored
    start(6'd8, 32'h8000, 24'd0);
    chk("len0_active", voice_active, 0);
    // three voices, two batches
    start(6'd2, 32'h2000, 24'd32);
    start(6'd5, 32'h5000, 24'd32);
    start(6'd63, 32'h6300, 24'd32);
    run(120);
    exp_req(2, 32'h2000, 16); exp_req(5, 32'h5000, 16); exp_req(63, 32'h6300, 16);
    exp_req(2, 32'h2040, 16); exp_req(5, 32'h5040, 16); exp_req(63, 32'h6340, 16);
    ex_last = '{63, 63};
    ex_done = '{2, 5, 63};
    check_all("three");
    chk("three_invalid", all_samples_invalid, 1);
    // backpressure
    bus.req_ready = 1'b0;
    start(6'd7, 32'h7000, 24'd16);
    wait_valid("bp");
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_valid%0d", i), bus.req_valid, 1);
      chk($sformatf("bp_addr%0d", i), bus.req_addr, 32'h7000);
      chk($sformatf("bp_len%0d", i), bus.req_len, 16);
      chk($sformatf("bp_id%0d", i), bus.req_id, 7);
      cyc();
    end
    bus.req_ready = 1'b1;
    run(60);
    exp_req(7, 32'h7000, 16);
    ex_last = '{7};
    ex_done = '{7};
    check_all("bp");
    // voice 10 joins the batch while voice 5 is being issued
    bus.req_ready = 1'b0;
    start(6'd5, 32'h5000, 24'd32);
    start(6'd63, 32'h6300, 24'd32);
    wait_valid("mid");
    chk("mid_first_id", bus.req_id, 5);
    start(6'd10, 32'hA000, 24'd16);
    bus.req_ready = 1'b1;
    run(120);
    exp_req(5, 32'h5000, 16); exp_req(10, 32'hA000, 16); exp_req(63, 32'h6300, 16);
    exp_req(5, 32'h5040, 16); exp_req(63, 32'h6340, 16);
    ex_last = '{63, 63};
    ex_done = '{10, 5, 63};
    check_all("mid");
    // stop in WAIT_BATCH
    start(6'd1, 32'h0100, 24'd32);
    for (int i = 0; i < 10 && q_last.size() == 0; i++) cyc();
    repeat (3) cyc();
    exp_req(1, 32'h0100, 16);
    ex_last = '{1};
    check_all("stopw_pre");
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("stopw_active", voice_active, 0);
    chk("stopw_valid", bus.req_valid, 0);
    chk("stopw_invalid", all_samples_invalid, 1);
    all_samples_received = 1'b1;
    cyc();
    all_samples_received = 1'b0;
    run(30);
    check_all("stopw_quiet");
    start(6'd1, 32'h0900, 24'd8);
    run(60);
    exp_req(1, 32'h0900, 8);
    ex_last = '{1};
    ex_done = '{1};
    check_all("stopw_restart");
    // stop in ISSUE
    bus.req_ready = 1'b0;
    start(6'd4, 32'h0400, 24'd16);
    wait_valid("stopi");
    chk("stopi_id", bus.req_id, 4);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("stopi_active", voice_active, 0);
    chk("stopi_valid", bus.req_valid, 0);
    run(30);
    check_all("stopi_quiet");
    bus.req_ready = 1'b1;
    start(6'd1, 32'h0A00, 24'd4);
    run(60);
    exp_req(1, 32'h0A00, 4);
    ex_last = '{1};
    ex_done = '{1};
    check_all("stopi_restart");
    // asynchronous reset mid-ISSUE
    bus.req_ready = 1'b0;
    start(6'd9, 32'h9000, 24'd16);
    wait_valid("arst");
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_valid", bus.req_valid, 0);
    chk("arst_active", voice_active, 0);
    chk("arst_invalid", all_samples_invalid, 1);
    chk("arst_addr", bus.req_addr, 0);
    chk("arst_id", bus.req_id, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
